// File: rtl/v_rams_sp_gen_pkg.sv
// ----------------------------------------------------------------------------
// rams_pkg
// Shared definitions for the single-port RAM template family:
//   - read-during-write mode constants (RAM_WRITE_FIRST / READ_FIRST / NO_CHANGE)
//   - clear-sequencer state type ram_clr_state_t {CLEAR, READY}
//   - mode_is_valid(): constant helper used by the elaboration check
// ----------------------------------------------------------------------------
package rams_pkg;

   localparam logic [1:0] RAM_WRITE_FIRST = 2'd0;
   localparam logic [1:0] RAM_READ_FIRST  = 2'd1;
   localparam logic [1:0] RAM_NO_CHANGE   = 2'd2;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } ram_clr_state_t;

   // True for the three supported read-during-write modes.
   function automatic logic mode_is_valid(input logic [1:0] mode);
      return (mode == RAM_WRITE_FIRST) ||
             (mode == RAM_READ_FIRST)  ||
             (mode == RAM_NO_CHANGE);
   endfunction

endpackage

// File: rtl/v_rams_sp_gen_if.sv
// ----------------------------------------------------------------------------
// v_rams_sp_gen_if
// User access port of the single-port RAM.
//   en       : access enable (ignored while busy)
//   we       : per-lane write enable, NB_COL bits
//   addr     : word address, ADDR_W bits
//   di       : write data, DATA_W bits
//   dout     : read data, DATA_W bits ("do" is a SystemVerilog keyword)
//   do_valid : one-cycle strobe marking new dout
//   busy     : high while the post-reset clear sequencer runs
// Modports: master = requester side, slave = RAM side.
// ----------------------------------------------------------------------------
interface v_rams_sp_gen_if #(
   parameter int DATA_W = 16,
   parameter int NB_COL = 2,
   parameter int ADDR_W = 6
) ();

   logic                en;
   logic [NB_COL-1:0]   we;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   di;
   logic [DATA_W-1:0]   dout;
   logic                do_valid;
   logic                busy;

   modport master (
      output en, we, addr, di,
      input  dout, do_valid, busy
   );

   modport slave (
      input  en, we, addr, di,
      output dout, do_valid, busy
   );

endinterface

// File: rtl/v_rams_sp_gen_clr.sv
// ----------------------------------------------------------------------------
// v_rams_sp_clr
// Post-reset memory-clear sequencer. After rst deasserts it walks the clear
// counter from 0 to DEPTH-1, one word per cycle, then parks in READY until the
// next rst. busy falls on the edge that writes the last word, so busy is high
// for exactly DEPTH cycles.
//   clk, rst  : clock, asynchronous active-high reset
//   busy      : sequencer running
//   clr_we    : write strobe for the array port while clearing
//   clr_addr  : address being cleared
// ----------------------------------------------------------------------------
module v_rams_sp_clr
   import rams_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

   ram_clr_state_t    state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              busy_q;

   // Clear FSM: counter, state and registered busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CLEAR;
         cnt_q   <= ZERO_ADDR;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            CLEAR: begin
               if (cnt_q == LAST_ADDR) begin
                  state_q <= READY;
                  cnt_q   <= ZERO_ADDR;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= CLEAR;
                  cnt_q   <= cnt_q + ADDR_W'(1);
                  busy_q  <= 1'b1;
               end
            end
            READY: begin
               state_q <= READY;
               cnt_q   <= ZERO_ADDR;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= CLEAR;
               cnt_q   <= ZERO_ADDR;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   // busy_q is high exactly while the FSM is in CLEAR.
   assign busy     = busy_q;
   assign clr_we   = busy_q;
   assign clr_addr = cnt_q;

endmodule

// File: rtl/v_rams_sp_gen.sv
// ----------------------------------------------------------------------------
// v_rams_sp_gen
// Parametrised single-port block RAM with per-lane write enables, selectable
// read-during-write MODE, a read-valid strobe and a post-reset clear sequencer.
//   clk  : clock (rising edge)
//   rst  : asynchronous active-high reset (sequencer and output flags only;
//          the array itself is only zeroed by the sequencer)
//   bus  : v_rams_sp_gen_if.slave (en, we, addr, di, dout, do_valid, busy)
// Optional feature macro: RAMS_SP_OUTREG_EN adds one output register stage
// (read latency 2 instead of 1, do_valid delayed by the same stage).
// ----------------------------------------------------------------------------
module v_rams_sp_gen
   import rams_pkg::*;
#(
   parameter int         DATA_W = 16,
   parameter int         COL_W  = 8,
   parameter int         NB_COL = 2,
   parameter int         DEPTH  = 64,
   parameter int         ADDR_W = $clog2(DEPTH),
   parameter logic [1:0] MODE   = RAM_WRITE_FIRST
) (
   input  logic          clk,
   input  logic          rst,
   v_rams_sp_gen_if.slave bus
);

   // Configuration sanity check at elaboration.
   generate
      if ((DATA_W != NB_COL * COL_W) || !mode_is_valid(MODE) || (DEPTH < 2)) begin : g_cfg_err
         $error("v_rams_sp_gen: DATA_W must equal NB_COL*COL_W, MODE must be valid, DEPTH >= 2");
      end
   endgenerate

   localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{1'b0}};
   localparam logic [NB_COL-1:0] NO_LANES  = {NB_COL{1'b0}};
   localparam logic [NB_COL-1:0] ALL_LANES = {NB_COL{1'b1}};

   logic              busy_s;
   logic              clr_we_s;
   logic [ADDR_W-1:0] clr_addr_s;

   v_rams_sp_clr #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_clr (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy_s),
      .clr_we   (clr_we_s),
      .clr_addr (clr_addr_s)
   );

   logic [DATA_W-1:0] mem [DEPTH];

   logic              acc_s;
   logic              in_range_s;
   logic              upd_s;
   logic              rd_load_s;
   logic              port_en_s;
   logic [NB_COL-1:0] port_we_s;
   logic [ADDR_W-1:0] port_addr_s;
   logic [DATA_W-1:0] port_di_s;
   logic [DATA_W-1:0] old_s;
   logic [DATA_W-1:0] merged_s;
   logic [DATA_W-1:0] rd_word_s;

   logic [DATA_W-1:0] rd_q;
   logic              valid_q, valid_d;
   logic              mask_q,  mask_d;
   logic [DATA_W-1:0] dout1_s;

   // Access qualification and dout update decision.
   always_comb begin
      acc_s      = bus.en & ~busy_s;
      in_range_s = (32'(bus.addr) < 32'(DEPTH));
      if (!acc_s) begin
         upd_s = 1'b0;
      end else if (!in_range_s) begin
         // Out-of-range: write dropped, dout forced to zero but still strobed.
         upd_s = 1'b1;
      end else if ((MODE == RAM_NO_CHANGE) && (|bus.we)) begin
         upd_s = 1'b0;
      end else begin
         upd_s = 1'b1;
      end
      rd_load_s = upd_s & in_range_s;
   end

   // Single array port: the clear sequencer owns it while busy, else the user.
   always_comb begin
      if (clr_we_s) begin
         port_en_s   = 1'b1;
         port_we_s   = ALL_LANES;
         port_addr_s = clr_addr_s;
         port_di_s   = ZERO_WORD;
      end else begin
         port_en_s   = acc_s & in_range_s;
         port_we_s   = (acc_s & in_range_s) ? bus.we : NO_LANES;
         port_addr_s = bus.addr;
         port_di_s   = bus.di;
      end
   end

   // Read word selection: merged (write-first) or pre-write (read-first) word.
   always_comb begin
      old_s    = mem[bus.addr];
      merged_s = old_s;
      for (int i = 0; i < NB_COL; i++) begin
         if (bus.we[i]) begin
            merged_s[i*COL_W +: COL_W] = bus.di[i*COL_W +: COL_W];
         end else begin
            merged_s[i*COL_W +: COL_W] = old_s[i*COL_W +: COL_W];
         end
      end
      if (MODE == RAM_READ_FIRST) begin
         rd_word_s = old_s;
      end else begin
         rd_word_s = merged_s;
      end
   end

   // Memory array and its read register; no reset so block RAM is inferred.
   always_ff @(posedge clk) begin
      if (port_en_s) begin
         for (int i = 0; i < NB_COL; i++) begin
            if (port_we_s[i]) begin
               mem[port_addr_s][i*COL_W +: COL_W] <= port_di_s[i*COL_W +: COL_W];
            end
         end
      end
      if (rd_load_s) begin
         rd_q <= rd_word_s;
      end
   end

   // Next-state for the valid strobe and the zero mask. The mask stands in
   // for a reset on rd_q: it forces dout to 0 after reset and on out-of-range.
   always_comb begin
      valid_d = upd_s;
      if (upd_s) begin
         mask_d = ~in_range_s;
      end else begin
         mask_d = mask_q;
      end
   end

   // Output flags with asynchronous reset; rst kills do_valid immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         mask_q  <= 1'b1;
      end else begin
         valid_q <= valid_d;
         mask_q  <= mask_d;
      end
   end

   assign dout1_s = mask_q ? ZERO_WORD : rd_q;

`ifdef RAMS_SP_OUTREG_EN
   logic [DATA_W-1:0] out_q, out_d;
   logic              out_v_q, out_v_d;

   // Extra output stage: captures only when stage 1 carries new data.
   always_comb begin
      out_v_d = valid_q;
      if (valid_q) begin
         out_d = dout1_s;
      end else begin
         out_d = out_q;
      end
   end

   // Output stage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q   <= ZERO_WORD;
         out_v_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         out_v_q <= out_v_d;
      end
   end

   assign bus.dout     = out_q;
   assign bus.do_valid = out_v_q;
`else
   assign bus.dout     = dout1_s;
   assign bus.do_valid = valid_q;
`endif

   assign bus.busy = busy_s;

endmodule

// File: tb/tb_v_rams_sp_gen.sv
// ----------------------------------------------------------------------------
// tb_v_rams_sp_gen
// Four RAM instances (write-first, read-first, no-change, and write-first with
// DEPTH=40) share one stimulus stream; a behavioural model per instance
// predicts dout, do_valid and busy every cycle.
// ----------------------------------------------------------------------------
module tb_v_rams_sp_gen;
   import rams_pkg::*;

   localparam int NDUT = 4;
`ifdef RAMS_SP_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        t_en   = 1'b0;
   logic [1:0]  t_we   = 2'b00;
   logic [5:0]  t_addr = 6'd0;
   logic [15:0] t_di   = 16'h0000;

   v_rams_sp_gen_if #(.DATA_W(16), .NB_COL(2), .ADDR_W(6)) if0 ();
   v_rams_sp_gen_if #(.DATA_W(16), .NB_COL(2), .ADDR_W(6)) if1 ();
   v_rams_sp_gen_if #(.DATA_W(16), .NB_COL(2), .ADDR_W(6)) if2 ();
   v_rams_sp_gen_if #(.DATA_W(16), .NB_COL(2), .ADDR_W(6)) if3 ();

   assign if0.en = t_en; assign if0.we = t_we; assign if0.addr = t_addr; assign if0.di = t_di;
   assign if1.en = t_en; assign if1.we = t_we; assign if1.addr = t_addr; assign if1.di = t_di;
   assign if2.en = t_en; assign if2.we = t_we; assign if2.addr = t_addr; assign if2.di = t_di;
   assign if3.en = t_en; assign if3.we = t_we; assign if3.addr = t_addr; assign if3.di = t_di;

   v_rams_sp_gen #(.DEPTH(64), .MODE(RAM_WRITE_FIRST)) u_wf  (.clk(clk), .rst(rst), .bus(if0));
   v_rams_sp_gen #(.DEPTH(64), .MODE(RAM_READ_FIRST))  u_rf  (.clk(clk), .rst(rst), .bus(if1));
   v_rams_sp_gen #(.DEPTH(64), .MODE(RAM_NO_CHANGE))   u_nc  (.clk(clk), .rst(rst), .bus(if2));
   v_rams_sp_gen #(.DEPTH(40), .MODE(RAM_WRITE_FIRST)) u_d40 (.clk(clk), .rst(rst), .bus(if3));

   logic [15:0] o_do   [NDUT];
   logic        o_v    [NDUT];
   logic        o_busy [NDUT];
   assign o_do[0] = if0.dout; assign o_v[0] = if0.do_valid; assign o_busy[0] = if0.busy;
   assign o_do[1] = if1.dout; assign o_v[1] = if1.do_valid; assign o_busy[1] = if1.busy;
   assign o_do[2] = if2.dout; assign o_v[2] = if2.do_valid; assign o_busy[2] = if2.busy;
   assign o_do[3] = if3.dout; assign o_v[3] = if3.do_valid; assign o_busy[3] = if3.busy;

   // Reference model state.
   int          m_depth [NDUT];
   logic [1:0]  m_mode  [NDUT];
   int          m_clr   [NDUT];
   logic [15:0] m_mem   [NDUT][64];
   logic [15:0] s1_do [NDUT], s2_do [NDUT];
   logic        s1_v  [NDUT], s2_v  [NDUT];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NDUT; k++) begin
         m_clr[k] = m_depth[k];
         for (int a = 0; a < 64; a++) m_mem[k][a] = 16'h0000;
         s1_do[k] = 16'h0000; s1_v[k] = 1'b0;
         s2_do[k] = 16'h0000; s2_v[k] = 1'b0;
      end
   endtask

   // One clock edge worth of behaviour for every instance.
   task automatic model_edge();
      for (int k = 0; k < NDUT; k++) begin
         logic        acc, r_v;
         logic [15:0] r_do, old_w, new_w;
         acc = t_en && (m_clr[k] == 0);
         if (m_clr[k] > 0) m_clr[k] = m_clr[k] - 1;
         r_v  = 1'b0;
         r_do = 16'h0000;
         if (acc) begin
            if (int'(t_addr) >= m_depth[k]) begin
               r_v = 1'b1;
            end else begin
               old_w = m_mem[k][t_addr];
               new_w = old_w;
               if (t_we[0]) new_w[7:0]  = t_di[7:0];
               if (t_we[1]) new_w[15:8] = t_di[15:8];
               m_mem[k][t_addr] = new_w;
               if (m_mode[k] == RAM_WRITE_FIRST) begin
                  r_v = 1'b1; r_do = new_w;
               end else if (m_mode[k] == RAM_READ_FIRST) begin
                  r_v = 1'b1; r_do = old_w;
               end else if (t_we == 2'b00) begin
                  r_v = 1'b1; r_do = old_w;
               end
            end
         end
         if (LAT == 2) begin
            s2_v[k] = s1_v[k];
            if (s1_v[k]) s2_do[k] = s1_do[k];
         end
         s1_v[k] = r_v;
         if (r_v) s1_do[k] = r_do;
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("%s.do%0d", tag, k),   32'(o_do[k]),   32'((LAT == 2) ? s2_do[k] : s1_do[k]));
         chk($sformatf("%s.v%0d", tag, k),    32'(o_v[k]),    32'((LAT == 2) ? s2_v[k]  : s1_v[k]));
         chk($sformatf("%s.busy%0d", tag, k), 32'(o_busy[k]), 32'(m_clr[k] > 0));
      end
   endtask

   task automatic step(input logic en, input logic [1:0] we, input logic [5:0] addr,
                       input logic [15:0] di, input string tag);
      t_en = en; t_we = we; t_addr = addr; t_di = di;
      @(posedge clk);
      #1;
      model_edge();
      check_all(tag);
   endtask

   task automatic rnd_step(input string tag);
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           6'($urandom_range(0, 63)), 16'($urandom), tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 6'd0, 16'h0000, tag);
   endtask

   // Asynchronous reset pulse; do_valid must drop and busy rise at once.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      check_all(tag);
      #2;
      rst = 1'b0;
   endtask

   initial begin
      m_depth[0] = 64; m_mode[0] = RAM_WRITE_FIRST;
      m_depth[1] = 64; m_mode[1] = RAM_READ_FIRST;
      m_depth[2] = 64; m_mode[2] = RAM_NO_CHANGE;
      m_depth[3] = 40; m_mode[3] = RAM_WRITE_FIRST;
      #2;
      do_reset("rst0");
      // Clear with random traffic that must be dropped.
      for (int i = 0; i < 66; i++) rnd_step("clear0");
      // Preload garbage everywhere, then reset-clear again.
      for (int a = 0; a < 64; a++) step(1'b1, 2'b11, 6'(a), 16'($urandom), "garbage");
      do_reset("rst1");
      for (int i = 0; i < 64; i++) rnd_step("clear1");
      step(1'b1, 2'b00, 6'd0,  16'h0000, "rd0");
      step(1'b1, 2'b00, 6'd31, 16'h0000, "rd31");
      step(1'b1, 2'b00, 6'd63, 16'h0000, "rd63");
      idle(2, "idle");
      chk("clr_rd63_wf", 32'(o_do[0]), 32'h0000);
      // Write-first merge and mode sweep.
      step(1'b1, 2'b11, 6'd5, 16'hAAAA, "wr5");
      step(1'b1, 2'b01, 6'd5, 16'h1234, "merge");
      idle(2, "idle");
      chk("wf_merge", 32'(o_do[0]), 32'hAA34);
      chk("rf_old",   32'(o_do[1]), 32'hAAAA);
      chk("nc_hold",  32'(o_do[2]), 32'h0000);
      step(1'b1, 2'b00, 6'd5, 16'h0000, "rd5");
      idle(2, "idle");
      chk("wf_rd5", 32'(o_do[0]), 32'hAA34);
      chk("nc_rd5", 32'(o_do[2]), 32'hAA34);
      // Out-of-range on the DEPTH=40 instance, then its alias must be intact.
      step(1'b1, 2'b11, 6'd45, 16'hFFFF, "oor");
      idle(2, "idle");
      chk("oor_zero", 32'(o_do[3]), 32'h0000);
      step(1'b1, 2'b00, 6'd5, 16'h0000, "alias");
      idle(2, "idle");
      chk("alias5", 32'(o_do[3]), 32'hAA34);
      // Reset during back-to-back reads, and again at clear count 20.
      for (int i = 0; i < 6; i++) step(1'b1, 2'b00, 6'(i), 16'h0000, "b2b");
      do_reset("rst_b2b");
      for (int i = 0; i < 20; i++) rnd_step("clear2");
      do_reset("rst_c20");
      for (int i = 0; i < 64; i++) rnd_step("clear3");
      // Randomised traffic.
      for (int i = 0; i < 400; i++) rnd_step("rand");
      // Streamed reads of 0..7 holding data=addr.
      for (int a = 0; a < 8; a++) step(1'b1, 2'b11, 6'(a), 16'(a), "fill");
      for (int a = 0; a < 8; a++) step(1'b1, 2'b00, 6'(a), 16'h0000, "stream");
      idle(3, "drain");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
